// File: rtl/led_event_scheduler.sv
// LED event scheduler: hit/miss flashes and game-over / game-clear lamp patterns,
// timed by a clk prescaler feeding a tick counter.
module led_event_scheduler #(
    parameter int TICK_DIV    = 50000,
    parameter int FLASH_TICKS = 100,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       hit_evt,
    input  logic       miss_evt,
    output logic [3:0] led_red,
    output logic [3:0] led_green,
    output logic [3:0] led_blue,
    output logic       busy
);

    localparam int MAX_TICKS = (FLASH_TICKS > BLINK_TICKS) ? FLASH_TICKS : BLINK_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;
    localparam int PW        = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        FLASH_HIT,
        FLASH_MISS,
        OVER_BLINK,
        CLEAR_CHASE
    } mode_t;

    mode_t         mode;
    logic [PW-1:0] pre;
    logic [TW-1:0] tcnt;
    logic          hit_prev;
    logic          miss_prev;

    logic hit_edge;
    logic miss_edge;
    logic tick;
    logic flash_end;
    logic blink_end;

    assign hit_edge  = hit_evt & ~hit_prev;
    assign miss_edge = miss_evt & ~miss_prev;
    assign tick      = (pre == PW'(TICK_DIV - 1));
    assign flash_end = tick && (tcnt == TW'(FLASH_TICKS - 1));
    assign blink_end = tick && (tcnt == TW'(BLINK_TICKS - 1));

    // NOTE: every register here is state, so all assignments are non-blocking;
    // later assignments in the same branch deliberately override the defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= IDLE;
            pre       <= '0;
            tcnt      <= '0;
            hit_prev  <= 1'b0;
            miss_prev <= 1'b0;
            led_red   <= 4'b0000;
            led_green <= 4'b0000;
            led_blue  <= 4'b0000;
            busy      <= 1'b0;
        end else begin
            hit_prev  <= hit_evt;
            miss_prev <= miss_evt;
            pre       <= tick ? '0 : pre + 1'b1;
            if (tick) tcnt <= tcnt + 1'b1;

            if (state == 3'd3) begin
                if (mode != OVER_BLINK) begin
                    mode      <= OVER_BLINK;
                    pre       <= '0;
                    tcnt      <= '0;
                    led_red   <= 4'b1111;
                    led_green <= 4'b0000;
                    led_blue  <= 4'b0000;
                    busy      <= 1'b1;
                end else if (blink_end) begin
                    tcnt    <= '0;
                    led_red <= ~led_red;
                end
            end else if (state == 3'd5) begin
                if (mode != CLEAR_CHASE) begin
                    mode      <= CLEAR_CHASE;
                    pre       <= '0;
                    tcnt      <= '0;
                    led_red   <= 4'b0000;
                    led_green <= 4'b0001;
                    led_blue  <= 4'b0000;
                    busy      <= 1'b1;
                end else if (blink_end) begin
                    tcnt      <= '0;
                    led_green <= {led_green[2:0], led_green[3]};
                end
            end else if (hit_edge && (mode == IDLE || mode == FLASH_HIT || mode == FLASH_MISS)) begin
                mode      <= FLASH_HIT;
                pre       <= '0;
                tcnt      <= '0;
                led_red   <= 4'b0000;
                led_green <= 4'b0000;
                led_blue  <= 4'b1111;
                busy      <= 1'b1;
            end else if (miss_edge && (mode == IDLE || mode == FLASH_MISS)) begin
                mode      <= FLASH_MISS;
                pre       <= '0;
                tcnt      <= '0;
                led_red   <= 4'b1111;
                led_green <= 4'b0000;
                led_blue  <= 4'b0000;
                busy      <= 1'b1;
            end else if (mode == OVER_BLINK || mode == CLEAR_CHASE || mode == IDLE || flash_end) begin
                // Pattern mode whose state code went away, idle, or flash expired.
                mode      <= IDLE;
                pre       <= '0;
                tcnt      <= '0;
                led_red   <= 4'b0000;
                led_green <= 4'b0000;
                led_blue  <= 4'b0000;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: doc/led_event_scheduler.md
LED_EVENT_SCHEDULER -- requirements
Module: led_event_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per internal tick (minimum 2).
REQ-002 SHALL have parameter FLASH_TICKS, default 100, meaning the length of a hit/miss flash in ticks (minimum 1).
REQ-003 SHALL have parameter BLINK_TICKS, default 250, meaning the blink half-period or chase step in ticks (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port state, input, 3 bits: game state code (3 = GAME OVER, 5 = GAME CLEAR, others = play/idle).
REQ-007 SHALL have port hit_evt, input, 1 bit: mole-hit event, synchronous to clk, any pulse width.
REQ-008 SHALL have port miss_evt, input, 1 bit: miss event, synchronous to clk, any pulse width.
REQ-009 SHALL have ports led_red, led_green and led_blue, each output, 4 bits, registered, active-high lamp enables.
REQ-010 SHALL have port busy, output, 1 bit, registered: high whenever the controller is not in IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, FLASH_HIT, FLASH_MISS, OVER_BLINK and CLEAR_CHASE.
REQ-012 SHALL detect events on rising edges only (input high, previous sample low); a held level SHALL NOT retrigger.
REQ-013 SHALL use a prescaler counting 0..TICK_DIV-1 that asserts an internal tick when it wraps from TICK_DIV-1 to 0.
REQ-014 SHALL have priority state==3 > state==5 > hit edge > miss edge, evaluated every cycle.
REQ-015 SHALL enter OVER_BLINK on the next edge, from any state, while state==3, ignoring any events.
REQ-016 SHALL enter CLEAR_CHASE on the next edge, from any state, while state==5 and state!=3, ignoring any events.
REQ-017 SHALL leave OVER_BLINK or CLEAR_CHASE for IDLE, with all LEDs 0, one cycle after state leaves that code.
REQ-018 SHALL treat a direct state change 3->5 or 5->3 as entry into the new mode, with a fresh pattern start.
REQ-019 SHALL, on a hit edge in IDLE, FLASH_HIT or FLASH_MISS, enter (or restart) FLASH_HIT: led_blue=1111, others 0000.
REQ-020 SHALL, on a miss edge in IDLE or FLASH_MISS, enter (or restart) FLASH_MISS: led_red=1111, others 0000.
REQ-021 SHALL ignore a miss edge during FLASH_HIT; on simultaneous hit and miss edges, hit wins.
REQ-022 SHALL clear the prescaler and the tick counter on every mode entry or restart, so a flash lasts exactly FLASH_TICKS*TICK_DIV cycles.
REQ-023 SHALL return from a flash to IDLE (LEDs 0000, busy 0) on the cycle after that duration elapses.
REQ-024 SHALL drive OVER_BLINK as led_red=1111 from entry for BLINK_TICKS ticks, then 0000 for BLINK_TICKS ticks, repeating, with green and blue 0.
REQ-025 SHALL drive CLEAR_CHASE as led_green one-hot 0001 at entry, rotating left (1000 wraps to 0001) every BLINK_TICKS ticks, with red and blue 0.
REQ-026 SHALL register outputs so that they reflect the new state one clk after the triggering input is sampled (latency 1).
REQ-027 SHALL size the tick counter at clog2(max(FLASH_TICKS,BLINK_TICKS))+1 bits and reload it to 0 at each period end (no overflow).

Reset
REQ-028 SHALL, while rst=1 and immediately (asynchronously), put the FSM in IDLE, LEDs 0000, busy 0, prescaler 0, tick counter 0 and edge-detect history 0.
REQ-029 SHALL, after a reset asserted mid-flash or mid-pattern, resume only on a new event or state; a level already high on hit_evt at release SHALL count as an edge.

Verification (TICK_DIV=4, FLASH_TICKS=2, BLINK_TICKS=2)
REQ-030 SHALL verify: 1-cycle hit_evt pulse from IDLE -> led_blue=1111 and busy=1 for exactly 8 cycles, then all 0.
REQ-031 SHALL verify: miss edge, then hit edge 3 cycles later -> red for 3 cycles, then blue for 8 cycles; a miss during blue leaves blue unchanged.
REQ-032 SHALL verify: state=3 held -> led_red alternates 1111/0000 every 8 cycles; a hit edge meanwhile has no effect; state=0 -> all 0 one cycle later.
REQ-033 SHALL verify: state=5 held 40 cycles -> led_green 0001,0010,0100,1000,0001 at 8-cycle steps.
REQ-034 SHALL verify: simultaneous hit and miss edges -> FLASH_HIT; hit_evt held high 20 cycles -> single 8-cycle flash.
REQ-035 SHALL verify: rst pulse mid-flash between clk edges -> outputs 0 immediately; no activity after release until a new event.
